// File: rtl/fetch_pkg.sv
// Shared widths and the instruction-buffer slot type for the fetch unit.
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INST_W  = 32;
   localparam int PC_STEP = 4;
   // Wide enough for several stacked redirect windows of discarded responses.
   localparam int DROP_W  = 8;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic              filled;
   } fetch_slot_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel plus the decode-side handshake.
interface instr_fetch_unit_if;
   import fetch_pkg::*;

   logic              imem_req_valid_o;
   logic              imem_req_ready_i;
   logic [XLEN-1:0]   imem_req_addr_o;
   logic              imem_rsp_valid_i;
   logic [INST_W-1:0] imem_rsp_data_i;
   logic              inst_valid_o;
   logic              inst_ready_i;
   logic [INST_W-1:0] inst_o;
   logic [XLEN-1:0]   inst_pc_o;

   modport master (
      output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
      input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, inst_ready_i
   );

   modport slave (
      input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
      output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, inst_ready_i
   );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: slots are reserved at request time, filled in order by
// responses and popped from the head; flush empties everything at once.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   reserve_i,
   input  logic [XLEN-1:0]        reserve_pc_i,
   input  logic                   fill_i,
   input  logic [INST_W-1:0]      fill_data_i,
   input  logic                   pop_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [$clog2(DEPTH):0] unfilled_o,
   output fetch_slot_t            head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_slot_t      slots_q [DEPTH];
   fetch_slot_t      slots_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
   logic [CNT_W-1:0] count_q, count_d, unfilled_q, unfilled_d;

   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      slots_d    = slots_q;
      head_d     = head_q;
      tail_d     = tail_q;
      fill_d     = fill_q;
      count_d    = count_q;
      unfilled_d = unfilled_q;
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) slots_d[i].filled = 1'b0;
         head_d     = '0;
         tail_d     = '0;
         fill_d     = '0;
         count_d    = '0;
         unfilled_d = '0;
      end else begin
         // Pop, reserve and fill always address three distinct slots.
         if (pop_i) begin
            slots_d[head_q].filled = 1'b0;
            head_d = head_q + 1'b1;
         end
         if (reserve_i) begin
            slots_d[tail_q].pc     = reserve_pc_i;
            slots_d[tail_q].filled = 1'b0;
            tail_d = tail_q + 1'b1;
         end
         if (fill_i) begin
            slots_d[fill_q].inst   = fill_data_i;
            slots_d[fill_q].filled = 1'b1;
            fill_d = fill_q + 1'b1;
         end
         count_d    = count_q + CNT_W'(reserve_i) - CNT_W'(pop_i);
         unfilled_d = unfilled_q + CNT_W'(reserve_i) - CNT_W'(fill_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: <= everywhere in sequential logic so every flop sees pre-edge values.
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         // NOTE: only the filled flags are reset; slot payload is never observed before it is rewritten.
         for (int i = 0; i < DEPTH; i++) slots_q[i].filled <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         fill_q     <= fill_d;
         count_q    <= count_d;
         unfilled_q <= unfilled_d;
         slots_q    <= slots_d;
      end
   end

   assign count_o    = count_q;
   assign unfilled_o = unfilled_q;
   assign head_o     = slots_q[head_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch control: request issue, next-PC selection, redirect flush and discard of
// stale responses. FETCH_MISALIGN_CHK_EN adds a sticky misaligned-target flag.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    pc_i,
   output logic [XLEN-1:0]    pc_next_o,
   input  logic               redirect_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic               misalign_o,
`endif
   instr_fetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [CNT_W-1:0]  count, unfilled;
   fetch_slot_t       head;
   logic [DROP_W-1:0] drop_q, drop_d, outstanding;
   logic              redirect, fire, pop, fill, fetch_en;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (redirect) misalign_d = (redirect_pc_i[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end

   assign misalign_o = misalign_q;
   assign fetch_en   = !misalign_q;
`else
   assign fetch_en = 1'b1;
`endif

   assign redirect = !rst && redirect_i;

   // A full buffer never issues, even when the head pops this cycle.
   assign bus.imem_req_valid_o = !rst && !redirect_i && fetch_en
                                 && (count < CNT_W'(FIFO_DEPTH));
   assign bus.imem_req_addr_o  = pc_i;
   assign fire = bus.imem_req_valid_o && bus.imem_req_ready_i;

   assign pc_next_o = redirect ? redirect_pc_i :
                      fire     ? pc_i + XLEN'(PC_STEP) : pc_i;

   assign bus.inst_valid_o = !rst && head.filled;
   assign bus.inst_o       = bus.inst_valid_o ? head.inst : '0;
   assign bus.inst_pc_o    = bus.inst_valid_o ? head.pc   : '0;
   assign pop = bus.inst_valid_o && bus.inst_ready_i;

   // Responses still owed by memory for requests the buffer no longer tracks.
   assign outstanding = drop_q + DROP_W'(unfilled);

   always_comb begin
      drop_d = drop_q;
      fill   = 1'b0;
      if (redirect) begin
         drop_d = outstanding
                  - DROP_W'(bus.imem_rsp_valid_i && (outstanding != '0));
      end else if (!rst && bus.imem_rsp_valid_i) begin
         if (drop_q != '0) drop_d = drop_q - 1'b1;
         else              fill   = (unfilled != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect),
      .reserve_i    (fire),
      .reserve_pc_i (pc_i),
      .fill_i       (fill),
      .fill_data_i  (bus.imem_rsp_data_i),
      .pop_i        (pop),
      .count_o      (count),
      .unfilled_o   (unfilled),
      .head_o       (head)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: the bench owns the PC register and a 1-cycle in-order memory.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, pc_next, redirect_pc;
   logic        redirect;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        misalign;
`endif

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .FIFO_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc),
      .pc_next_o     (pc_next),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
`ifdef FETCH_MISALIGN_CHK_EN
      .misalign_o    (misalign),
`endif
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          mem_on;
   logic [31:0] mq[$];
   logic [31:0] fired[$];
   logic [31:0] dl_pc[$];
   logic [31:0] dl_inst[$];
   logic        s_req_valid, s_inst_valid, s_fire;
   logic [31:0] s_addr, s_pc_next, s_inst_pc, s_inst;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock cycle: sample before the edge, then update PC register and memory.
   task automatic tick();
      #1;
      s_req_valid  = bus.imem_req_valid_o;
      s_addr       = bus.imem_req_addr_o;
      s_pc_next    = pc_next;
      s_inst_valid = bus.inst_valid_o;
      s_inst_pc    = bus.inst_pc_o;
      s_inst       = bus.inst_o;
      s_fire       = s_req_valid && bus.imem_req_ready_i;
      if (s_fire) fired.push_back(s_addr);
      if (s_inst_valid && bus.inst_ready_i) begin
         dl_pc.push_back(s_inst_pc);
         dl_inst.push_back(s_inst);
      end
      @(posedge clk);
      @(negedge clk);
      pc = s_pc_next;
      if (rst) begin
         mq.delete();
         bus.imem_rsp_valid_i = 1'b0;
      end else begin
         if (s_fire) mq.push_back(s_addr);
         if (mem_on && mq.size() > 0) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mem_data(mq.pop_front());
         end else begin
            bus.imem_rsp_valid_i = 1'b0;
         end
      end
   endtask

   task automatic start(input logic [31:0] pc0);
      rst      = 1'b1;
      redirect = 1'b0;
      mem_on   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      fired.delete();
      dl_pc.delete();
      dl_inst.delete();
      pc = pc0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                  = 1'b1;
      pc                   = 32'h1234_5678;
      redirect             = 1'b0;
      redirect_pc          = '0;
      mem_on               = 1'b0;
      bus.imem_req_ready_i = 1'b1;
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = 32'hFFFF_FFFF;
      bus.inst_ready_i     = 1'b1;

      // Reset state, with a stray response present
      tick();
      check("rst_req_valid", s_req_valid, 0);
      check("rst_inst_valid", s_inst_valid, 0);
      check("rst_pc_next", s_pc_next, 32'h1234_5678);
      check("rst_inst", s_inst, 0);
      check("rst_inst_pc", s_inst_pc, 0);

      // Streaming fetch from 0 with a 1-cycle memory
      start(32'h0);
      mem_on = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 0) check("seq_first_req", s_req_valid, 1);
         if (c == 1) check("seq_not_yet_valid", s_inst_valid, 0);
         if (c == 2) begin
            check("seq_latency_valid", s_inst_valid, 1);
            check("seq_latency_pc", s_inst_pc, 32'h0);
         end
         if (s_fire) check("seq_pc_next", s_pc_next, s_addr + 32'd4);
      end
      for (int i = 0; i < 3; i++) begin
         check("seq_req_addr", at(fired, i), 32'(4 * i));
         check("seq_inst_pc", at(dl_pc, i), 32'(4 * i));
      end
      check("seq_inst_data", at(dl_inst, 1), mem_data(32'h4));

      // Decode stalled: exactly two fires, then hold
      start(32'h40);
      mem_on = 1'b1;
      bus.inst_ready_i = 1'b0;
      repeat (6) tick();
      check("stall_fires", fired.size(), 2);
      check("stall_req_valid", s_req_valid, 0);
      check("stall_pc_next", s_pc_next, 32'h48);
      check("stall_head_pc", s_inst_pc, 32'h40);
      bus.inst_ready_i = 1'b1;
      tick();
      check("full_pop_no_fire", s_req_valid, 0);
      check("full_pop_valid", s_inst_valid, 1);
      tick();
      check("after_pop_fire", s_req_valid, 1);
      check("after_pop_addr", s_addr, 32'h48);
      check("after_pop_inst_pc", s_inst_pc, 32'h44);

      // Reset with a full buffer
      start(32'h80);
      mem_on = 1'b1;
      bus.inst_ready_i = 1'b0;
      repeat (5) tick();
      check("full_before_rst", s_inst_valid, 1);
      rst = 1'b1;
      tick();
      check("rst_full_req_valid", s_req_valid, 0);
      check("rst_full_inst_valid", s_inst_valid, 0);
      tick();
      check("rst_next_req_valid", s_req_valid, 0);
      check("rst_next_inst_valid", s_inst_valid, 0);
      rst = 1'b0;
      tick();
      check("post_rst_empty", s_inst_valid, 0);
      check("post_rst_req_addr", s_addr, 32'h88);

      // Redirect with two requests in flight
      start(32'h0);
      bus.inst_ready_i = 1'b1;
      tick();
      tick();
      check("redir_inflight", fired.size(), 2);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      mem_on      = 1'b1;
      tick();
      check("redir_no_req", s_req_valid, 0);
      check("redir_pc_next", s_pc_next, 32'h100);
      redirect = 1'b0;
      repeat (6) tick();
      check("redir_next_req", at(fired, 2), 32'h100);
      check("redir_first_pc", at(dl_pc, 0), 32'h100);
      check("redir_first_inst", at(dl_inst, 0), mem_data(32'h100));

      // Response arriving in the redirect cycle is dropped
      start(32'h200);
      mem_on = 1'b1;
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      repeat (5) tick();
      check("redir_same_cycle_pc", at(dl_pc, 0), 32'h300);
      check("redir_same_cycle_inst", at(dl_inst, 0), mem_data(32'h300));

      // Back-to-back redirects accumulate drops; last target wins
      start(32'h0);
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h500;
      tick();
      redirect_pc = 32'h600;
      mem_on      = 1'b1;
      tick();
      check("b2b_pc_next", s_pc_next, 32'h600);
      redirect = 1'b0;
      repeat (8) tick();
      check("b2b_first_pc", at(dl_pc, 0), 32'h600);
      check("b2b_first_inst", at(dl_inst, 0), mem_data(32'h600));

      // PC wrap at the top of the address space
      start(32'hFFFF_FFFC);
      mem_on = 1'b1;
      tick();
      check("wrap_addr", s_addr, 32'hFFFF_FFFC);
      check("wrap_pc_next", s_pc_next, 32'h0);

`ifdef FETCH_MISALIGN_CHK_EN
      // Misaligned redirect stalls fetch until an aligned one arrives
      start(32'h0);
      mem_on      = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
      tick();
      check("misalign_set", misalign, 1);
      check("misalign_no_req", s_req_valid, 0);
      tick();
      check("misalign_hold_req", s_req_valid, 0);
      check("misalign_pc_hold", s_pc_next, 32'h102);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      tick();
      check("misalign_clear", misalign, 0);
      check("misalign_resume", s_req_valid, 1);
      check("misalign_resume_addr", s_addr, 32'h200);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning instruction buffer entries and max in-flight requests; power of 2, >= 2.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port pc_i  in  32  current PC from the program counter register.
REQ-005 SHALL have port pc_next_o  out  32  next PC, wired to the program counter data input.
REQ-006 SHALL have port redirect_i  in  1  branch/jump redirect strobe.
REQ-007 SHALL have port redirect_pc_i  in  32  redirect target address.
REQ-008 SHALL have ports imem_req_valid_o out 1, imem_req_ready_i in 1, imem_req_addr_o out 32: instruction memory request channel.
REQ-009 SHALL have ports imem_rsp_valid_i in 1, imem_rsp_data_i in 32: in-order response channel, no backpressure.
REQ-010 SHALL have ports inst_valid_o out 1, inst_ready_i in 1, inst_o out 32, inst_pc_o out 32: decode-side handshake.

Function
REQ-011 SHALL reserve one buffer slot per accepted request; fire = imem_req_valid_o & imem_req_ready_i.
REQ-012 SHALL assert imem_req_valid_o iff !rst & !redirect_i & (occupied slots, including in-flight) < FIFO_DEPTH; imem_req_addr_o = pc_i.
REQ-013 SHALL drive pc_next_o combinationally: redirect_i ? redirect_pc_i : fire ? pc_i+4 (mod 2^32, wraps 0xFFFFFFFC->0) : pc_i.
REQ-014 SHALL record the request address in the reserved slot at fire; response data fills the oldest unfilled slot.
REQ-015 SHALL present the head slot on inst_o/inst_pc_o with inst_valid_o=1 only once it is filled; pop on inst_valid_o & inst_ready_i.
REQ-016 SHALL accept fire, response fill and pop in the same cycle without loss; a full buffer with a pop SHALL NOT allow a same-cycle fire (no bypass).
REQ-017 SHALL minimum latency: fire at edge N, response at N+1, inst_valid_o high after edge N+1.
REQ-018 SHALL on redirect_i: empty buffer, move unfilled in-flight count into drop counter, issue nothing that cycle.
REQ-019 SHALL discard responses while drop counter > 0, decrementing per response; a response in the redirect cycle counts as dropped.
REQ-020 SHALL permit new requests after redirect before drops complete; new responses are accepted only after drop counter reaches 0.
REQ-021 SHALL treat back-to-back redirects cumulatively; last target wins.

Reset
REQ-022 SHALL while rst: buffer empty, drop counter 0, inst_valid_o=0, imem_req_valid_o=0, pc_next_o=pc_i, inst_o=0, inst_pc_o=0.
REQ-023 SHALL ignore responses during rst and abandon in-flight requests; the memory side is reset concurrently.

Configuration
REQ-024 SHALL with FETCH_MISALIGN_CHK_EN defined: add port misalign_o out 1; redirect_pc_i[1:0]!=0 sets sticky misalign_o, suppresses requests until an aligned redirect or rst clears it.
REQ-025 SHALL without FETCH_MISALIGN_CHK_EN: no misalign_o port; redirect target used unchecked, low bits passed through.

Structure
REQ-026 SHALL place XLEN=32, INST_W=32, PC_STEP=4 and the slot struct (pc, inst, filled) in package fetch_pkg.
REQ-027 SHALL implement the buffer as sub-module fetch_fifo (reserve/fill/pop/flush, occupancy count); control in instr_fetch_unit.

Verification
REQ-028 SHALL cover: pc_i=0x0, ready=1, 1-cycle memory -> requests 0x0,0x4,0x8; inst_pc_o in order, pc_next_o=pc_i+4 each fire.
REQ-029 SHALL cover: inst_ready_i=0, FIFO_DEPTH=2 -> exactly 2 fires, then imem_req_valid_o=0, pc_next_o holds.
REQ-030 SHALL cover: 2 in-flight, redirect_i to 0x100 -> both late responses dropped, first delivered inst_pc_o=0x100.
REQ-031 SHALL cover: pc_i=0xFFFFFFFC fire -> pc_next_o=0x0.
REQ-032 SHALL cover: rst asserted with full buffer -> next cycle inst_valid_o=0, imem_req_valid_o=0.
REQ-033 SHALL cover (FETCH_MISALIGN_CHK_EN): redirect to 0x102 -> misalign_o=1, no requests; redirect to 0x200 -> cleared, fetch resumes.
